load_sequencer: RTL and testbench
=================================

# load_sequencer

Load sequencer between the processor's load/store unit and the data-memory port. It accepts one load request at a time (byte, halfword or word, optionally sign-extended) and issues one or two word reads on the memory bus. A second read is issued when the access crosses a word boundary. The block merges the returned bytes, aligns them to bit 0 and presents the result through a valid/ready handshake. Byte order is big-endian throughout: byte offset 0 is bits 31:24 of a memory word.

## Interface
Parameters:
- none; widths are fixed by `Pu_types::Word` (32 bit).

Ports:
- `clk`  in  1  — single clock; all state changes on the rising edge.
- `reset`  in  1  — asynchronous, active-low reset.
- `req_valid`  in  1  — load request present.
- `req_ready`  out  1  — block can accept a request; high only in IDLE.
- `req_addr`  in  32  — byte address.
- `req_mode`  in  `Pu_types::Load_mode`  — Load_byte / Load_halfword / Load_word.
- `req_signed`  in  1  — sign-extend byte/halfword results.
- `mem_en`  out  1  — memory read request.
- `mem_addr`  out  30  — word address.
- `mem_ack`  in  1  — read data valid this cycle; may be high in the same cycle `mem_en` is first asserted.
- `mem_rdata`  in  32  — read data, sampled when `mem_ack`=1.
- `res_valid`  out  1  — result available.
- `res_data`  out  32  — aligned result.
- `res_ready`  in  1  — consumer accepts the result.

## Operation
State machine: IDLE, FIRST, SECOND, DONE.
- **IDLE**
  - `req_ready`=1.
  - On `req_valid`, latch addr/mode/signed and go to FIRST.
  - Compute `split` = (word and addr[1:0]≠0) or (halfword and addr[1:0]=3). Byte loads never split.
- **FIRST**
  - `mem_en`=1, `mem_addr`=addr[31:2].
  - On `mem_ack`, latch the data into w0.
  - Go to SECOND if `split`, else DONE.
- **SECOND**
  - `mem_en`=1, `mem_addr`=addr[31:2]+1, modulo 2^30: 0x3FFFFFFF wraps to 0.
  - On `mem_ack`, latch the data into w1 and go to DONE.
- **DONE**
  - `res_valid`=1.
  - On `res_ready`, go to IDLE.
- Result extraction uses the 64-bit concatenation {w0,w1}:
  - take N bytes (1/2/4) starting at byte offset addr[1:0], counted from the MSB;
  - place them in the low bits of `res_data`;
  - upper bits are zero, or copies of the extracted MSB when `req_signed`=1 and mode≠word.
- `mem_en` stays high with a stable `mem_addr` until `mem_ack`. Only one memory request is outstanding at a time.
- `mem_ack` outside FIRST/SECOND is ignored.
- `res_data` is registered and held stable while `res_valid`=1 and `res_ready`=0.

## Timing
- Reset values: state=IDLE, `req_ready`=1, `mem_en`=0, `mem_addr`=0, `res_valid`=0, `res_data`=0. Captured w0/w1 are also cleared.
- Reset asserted in any state aborts the load immediately. No result is delivered after release.
- Latency with zero-wait memory (request accepted at cycle 0):
  - non-split: `mem_en` in cycle 1, `res_valid` in cycle 2;
  - split: `mem_en` in cycles 1–2, `res_valid` in cycle 3.
  - Each memory wait cycle adds one cycle.
- Throughput:
  - `req_ready` is low from the cycle after acceptance until the cycle after the result handshake.
  - Back-to-back minimum spacing is 3 cycles (non-split) or 4 (split).
- A request is never accepted in the same cycle a result is handed off.

## Structure
- `Pu_types` gains two entries:
  - enum `Load_seq_state` (IDLE, FIRST, SECOND, DONE);
  - function `load_size(Load_mode)` returning the byte count.
- One combinational sub-module, `load_extract`:
  - inputs: {w0,w1}, offset, mode, signed;
  - output: aligned 32-bit word.
- `load_sequencer` holds the FSM, the request registers and the data registers.

## Test plan
Memory: word 0x100 = 0x11223344, word 0x104 = 0xA5667788; `mem_ack` in the same cycle as `mem_en` unless stated.
- **Aligned word:** word load at 0x100 → one access (word addr 0x40); `res_data`=0x11223344; `res_valid` in cycle 2.
- **Byte loads:** byte at 0x103, unsigned → 0x00000044. Byte at 0x104, signed → 0xFFFFFFA5. Each uses a single access.
- **Split halfword:** halfword at 0x103 → accesses to 0x40 then 0x41; result 0x000044A5. Signed variant gives the same value (MSB of 0x44 is 0).
- **Split word with memory waits:** word at 0x102, `mem_ack` delayed 2 cycles on each access → result 0x3344A566. `mem_addr` is stable during the waits; `res_valid` in cycle 7.
- **Address wrap:** word at 0xFFFFFFFF → `mem_addr` 0x3FFFFFFF, then 0x00000000.
- **Backpressure and reset:**
  - `res_ready` low for 3 cycles → `res_data` stable, `req_ready`=0.
  - `reset` asserted while in SECOND → all outputs at reset values; after release `req_ready`=1 and no `res_valid` appears.

Source files
------------

// File: rtl/load_sequencer_pkg.sv
// Shared processor-unit types: load modes, sequencer states and size helpers.
package Pu_types;

    typedef logic [31:0] Word;

    typedef enum logic [1:0] {
        Load_byte     = 2'd0,
        Load_halfword = 2'd1,
        Load_word     = 2'd2
    } Load_mode;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FIRST  = 2'd1,
        SECOND = 2'd2,
        DONE   = 2'd3
    } Load_seq_state;

    function automatic logic [2:0] load_size(input Load_mode mode);
        case (mode)
            Load_byte:     load_size = 3'd1;
            Load_halfword: load_size = 3'd2;
            default:       load_size = 3'd4;
        endcase
    endfunction

    // True when the access touches bytes of the following word as well.
    function automatic logic load_split(input Load_mode mode, input logic [1:0] offset);
        case (mode)
            Load_word:     load_split = (offset != 2'd0);
            Load_halfword: load_split = (offset == 2'd3);
            default:       load_split = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/load_sequencer_extract.sv
// Combinational byte extraction from a big-endian word pair; aligns to bit 0
// and zero- or sign-extends sub-word results.
module load_extract
    import Pu_types::*;
(
    input  logic [63:0] words,
    input  logic [1:0]  offset,
    input  Load_mode    mode,
    input  logic        is_signed,
    output Word         data
);

    logic [63:0] shifted;
    Word         top;
    logic        ext;

    always_comb begin
        // Bring the first requested byte to bits 63:56, then pick N bytes.
        shifted = words << {offset, 3'b000};
        top     = shifted[63:32];
        ext     = is_signed & top[31];
        case (mode)
            Load_byte:     data = {{24{ext}}, top[31:24]};
            Load_halfword: data = {{16{ext}}, top[31:16]};
            default:       data = top;
        endcase
    end

endmodule

// File: rtl/load_sequencer.sv
// Load sequencer: one load at a time, one or two word reads, registered result.
// Result latency 2 cycles (3 if split) plus memory waits; holds result until res_ready.
module load_sequencer
    import Pu_types::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  Load_mode    req_mode,
    input  logic        req_signed,
    output logic        mem_en,
    output logic [29:0] mem_addr,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        res_valid,
    output logic [31:0] res_data,
    input  logic        res_ready
);

    Load_seq_state state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    Load_mode      mode_q, mode_d;
    logic          signed_q, signed_d;
    logic          split_q, split_d;
    Word           w0_q, w0_d;
    Word           w1_q, w1_d;
    Word           res_q, res_d;
    Word           extracted;
    logic          load_res;

    load_extract u_extract (
        .words     ({w0_d, w1_d}),
        .offset    (addr_q[1:0]),
        .mode      (mode_q),
        .is_signed (signed_q),
        .data      (extracted)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        mode_d    = mode_q;
        signed_d  = signed_q;
        split_d   = split_q;
        w0_d      = w0_q;
        w1_d      = w1_q;
        load_res  = 1'b0;
        req_ready = 1'b0;
        mem_en    = 1'b0;
        mem_addr  = 30'd0;
        res_valid = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    addr_d   = req_addr;
                    mode_d   = req_mode;
                    signed_d = req_signed;
                    split_d  = load_split(req_mode, req_addr[1:0]);
                    state_d  = FIRST;
                end
            end
            FIRST: begin
                mem_en   = 1'b1;
                mem_addr = addr_q[31:2];
                if (mem_ack) begin
                    w0_d     = mem_rdata;
                    load_res = !split_q;
                    state_d  = split_q ? SECOND : DONE;
                end
            end
            SECOND: begin
                mem_en   = 1'b1;
                mem_addr = addr_q[31:2] + 30'd1;
                if (mem_ack) begin
                    w1_d     = mem_rdata;
                    load_res = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Result is formed from the just-captured words so it is ready on entry to DONE.
        res_d = load_res ? extracted : res_q;
    end

    assign res_data = res_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            addr_q   <= 32'd0;
            mode_q   <= Load_byte;
            signed_q <= 1'b0;
            split_q  <= 1'b0;
            w0_q     <= '0;
            w1_q     <= '0;
            res_q    <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            mode_q   <= mode_d;
            signed_q <= signed_d;
            split_q  <= split_d;
            w0_q     <= w0_d;
            w1_q     <= w1_d;
            res_q    <= res_d;
        end
    end

endmodule

// File: tb/tb_load_sequencer.sv
// Scoreboard bench for load_sequencer: byte-level memory model, randomized waits and backpressure.
module tb_load_sequencer;
    import Pu_types::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    Load_mode    req_mode;
    logic        req_signed;
    logic        mem_en;
    logic [29:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;

    load_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .req_mode   (req_mode),
        .req_signed (req_signed),
        .mem_en     (mem_en),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_ready  (res_ready)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic [29:0] addr_q[$];
    int          delay_cfg = 0;
    int          lowcnt = 0;
    bit          rand_bp = 1'b0;
    int          acc_cyc = 0;
    bit          in_result = 1'b0;
    logic [31:0] held;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s", name);
    endtask

    function automatic logic [31:0] mem_word(input logic [29:0] w);
        if (w == 30'h40) return 32'h11223344;
        if (w == 30'h41) return 32'hA5667788;
        return ({2'b00, w} * 32'h9E3779B1) ^ 32'h5A5A5A5A;
    endfunction

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [31:0] w;
        w = mem_word(a[31:2]);
        return 8'(w >> (8 * (3 - int'(a[1:0]))));
    endfunction

    // Reference: read N consecutive bytes (address space wraps), first byte most significant.
    function automatic logic [31:0] model_result(input logic [31:0] a, input int n, input bit s);
        logic [31:0] r;
        logic [31:0] mask;
        r = 32'd0;
        for (int i = 0; i < n; i++) r = (r << 8) | {24'd0, mem_byte(a + 32'(i))};
        if (s && n < 4) begin
            mask = (32'd1 << (8 * n)) - 32'd1;
            if (r[8*n-1]) r = r | ~mask;
        end
        return r;
    endfunction

    function automatic int nbytes(input Load_mode m);
        return (m == Load_byte) ? 1 : (m == Load_halfword) ? 2 : 4;
    endfunction

    // Memory responder: acks after delay_cfg (or random 0..2) wait cycles, checks addresses.
    initial begin
        bit          busy;
        int          cnt;
        logic [29:0] cur;
        busy = 1'b0;
        cnt = 0;
        cur = '0;
        mem_ack = 1'b0;
        mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            mem_ack = 1'b0;
            if (!reset) begin
                busy = 1'b0;
            end else if (mem_en) begin
                if (!busy) begin
                    busy = 1'b1;
                    cur = mem_addr;
                    cnt = (delay_cfg < 0) ? int'($urandom_range(0, 2)) : delay_cfg;
                    if (addr_q.size() == 0) fail_now("unexpected_mem_request");
                    else chk("mem_addr", {2'b00, mem_addr}, {2'b00, addr_q.pop_front()});
                end else begin
                    chk("mem_addr_stable", {2'b00, mem_addr}, {2'b00, cur});
                end
                if (cnt == 0) begin
                    mem_ack = 1'b1;
                    mem_rdata = mem_word(mem_addr);
                    busy = 1'b0;
                end else begin
                    cnt--;
                    mem_rdata = $urandom;
                end
            end else begin
                busy = 1'b0;
                mem_rdata = $urandom;
                mem_ack = ($urandom_range(0, 3) == 0);
            end
        end
    end

    // Result monitor: drives res_ready, pops the scoreboard on each new result.
    initial begin
        logic [31:0] e;
        int          l;
        res_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_result = 1'b0;
                res_ready = 1'b0;
            end else begin
                if (res_valid && lowcnt > 0) begin
                    res_ready = 1'b0;
                    lowcnt--;
                end else begin
                    res_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
                end
                if (res_valid) begin
                    chk("req_ready_while_valid", {31'd0, req_ready}, 32'd0);
                    if (!in_result) begin
                        in_result = 1'b1;
                        held = res_data;
                        if (exp_q.size() == 0) begin
                            fail_now("unexpected_result");
                        end else begin
                            e = exp_q.pop_front();
                            l = lat_q.pop_front();
                            chk("res_data", res_data, e);
                            if (l >= 0) chk("latency", 32'(cyc - acc_cyc), 32'(l));
                        end
                    end else begin
                        chk("res_data_hold", res_data, held);
                    end
                    if (res_ready) in_result = 1'b0;
                end
            end
        end
    end

    task automatic issue(input logic [31:0] a, input Load_mode m, input bit s, input int lat);
        int          n;
        logic [31:0] last;
        n = nbytes(m);
        exp_q.push_back(model_result(a, n, s));
        lat_q.push_back(lat);
        last = a + 32'(n - 1);
        addr_q.push_back(a[31:2]);
        if (last[31:2] != a[31:2]) addr_q.push_back(last[31:2]);
        req_addr = a;
        req_mode = m;
        req_signed = s;
        req_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) fail_now("accept_timeout");
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_addr = $urandom;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(exp_q.size() == 0 && !in_result && req_ready) && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (n >= 500) fail_now("idle_timeout");
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
        chk({tag, "_mem_en"}, {31'd0, mem_en}, 32'd0);
        chk({tag, "_mem_addr"}, {2'b00, mem_addr}, 32'd0);
        chk({tag, "_res_valid"}, {31'd0, res_valid}, 32'd0);
        chk({tag, "_res_data"}, res_data, 32'd0);
    endtask

    initial begin
        int          n;
        logic [31:0] a;
        reset = 1'b0;
        req_valid = 1'b0;
        req_addr = 32'd0;
        req_mode = Load_byte;
        req_signed = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        delay_cfg = 0;
        rand_bp = 1'b0;
        issue(32'h100, Load_word, 1'b0, 2);
        wait_idle();
        issue(32'h103, Load_byte, 1'b0, 2);
        wait_idle();
        issue(32'h104, Load_byte, 1'b1, 2);
        wait_idle();
        issue(32'h103, Load_halfword, 1'b0, 3);
        wait_idle();
        issue(32'h103, Load_halfword, 1'b1, 3);
        wait_idle();
        delay_cfg = 2;
        issue(32'h102, Load_word, 1'b0, 7);
        wait_idle();
        delay_cfg = 0;
        issue(32'hFFFFFFFF, Load_word, 1'b0, 3);
        wait_idle();
        lowcnt = 3;
        issue(32'h100, Load_word, 1'b0, 2);
        wait_idle();
        // Back-to-back without waiting for idle in between.
        issue(32'h101, Load_halfword, 1'b1, -1);
        issue(32'h106, Load_halfword, 1'b1, -1);
        issue(32'h107, Load_byte, 1'b1, -1);
        wait_idle();

        // Abort a load while it is waiting on its second access.
        delay_cfg = 2;
        issue(32'h102, Load_word, 1'b0, -1);
        n = 0;
        @(negedge clk);
        while (!(mem_en && mem_addr == 30'h41) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) fail_now("second_access_timeout");
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        exp_q.delete();
        lat_q.delete();
        addr_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (8) begin
            @(negedge clk);
            chk("post_abort_res_valid", {31'd0, res_valid}, 32'd0);
        end
        chk("post_abort_req_ready", {31'd0, req_ready}, 32'd1);
        @(posedge clk);
        #1;

        delay_cfg = -1;
        rand_bp = 1'b1;
        for (int i = 0; i < 150; i++) begin
            case ($urandom_range(0, 3))
                0: a = $urandom;
                1: a = 32'hFFFFFFFC + 32'($urandom_range(0, 3));
                default: a = 32'h100 + 32'($urandom_range(0, 11));
            endcase
            issue(a, Load_mode'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), -1);
        end
        wait_idle();
        if (addr_q.size() != 0) fail_now("leftover_mem_requests");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
